// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell codes, board geometry, direction tables and
// the move-resolution sequencer state encoding.
package othello_pkg;

    localparam int BOARD_DIM = 8;
    localparam int COORD_W   = $clog2(BOARD_DIM);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    // Index order: E, SE, S, SW, W, NW, N, NE (y grows downward)
    localparam logic signed [1:0] DIR_DX [8] = '{2'sb01, 2'sb01, 2'sb00, 2'sb11,
                                                 2'sb11, 2'sb11, 2'sb00, 2'sb01};
    localparam logic signed [1:0] DIR_DY [8] = '{2'sb00, 2'sb01, 2'sb01, 2'sb01,
                                                 2'sb00, 2'sb11, 2'sb11, 2'sb11};

    typedef enum logic [3:0] {
        IDLE,
        ORG_RD,
        ORG_WAIT,
        DIR_INIT,
        STEP_RD,
        STEP_WAIT,
        STEP_EVAL,
        BACK_WR,
        BACK_DRAW,
        NEXT_DIR,
        PLACE_WR,
        PLACE_DRAW,
        FINISH
    } state_t;

endpackage

// File: rtl/board_step.sv
// Combinational walk helper: the cell k steps away from (x,y) along a direction,
// plus whether that cell is still on the board.
module board_step
    import othello_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [2:0]         dir,
    input  logic [3:0]         k,
    output logic [COORD_W-1:0] nx,
    output logic [COORD_W-1:0] ny,
    output logic               in_bounds
);

    logic [3:0] off_x;
    logic [3:0] off_y;
    logic [3:0] sum_x;
    logic [3:0] sum_y;

    // 4-bit two's complement: any result outside 0..7 lands with bit 3 set,
    // so leaving the board can never alias onto the opposite edge.
    always_comb begin
        off_x = 4'd0;
        off_y = 4'd0;
        if (DIR_DX[dir] == 2'sb01) begin
            off_x = k;
        end else if (DIR_DX[dir] == 2'sb11) begin
            off_x = -k;
        end
        if (DIR_DY[dir] == 2'sb01) begin
            off_y = k;
        end else if (DIR_DY[dir] == 2'sb11) begin
            off_y = -k;
        end
        sum_x     = {1'b0, x} + off_x;
        sum_y     = {1'b0, y} + off_y;
        nx        = sum_x[COORD_W-1:0];
        ny        = sum_y[COORD_W-1:0];
        in_bounds = !sum_x[3] && !sum_y[3];
    end

endmodule

// File: rtl/flip_sequencer.sv
// Othello move resolver: scans the 8 rays from a candidate cell, counts captures,
// and in commit mode writes flipped/placed disks and requests their redraw.
module flip_sequencer
    import othello_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       start,
    input  logic       commit,
    input  logic [2:0] pos_x,
    input  logic [2:0] pos_y,
    input  logic       side,
    output logic [5:0] mem_addr,
    output logic       mem_rd,
    input  logic [1:0] mem_rdata,
    output logic       mem_we,
    output logic [1:0] mem_wdata,
    output logic       draw_req,
    output logic [2:0] draw_x,
    output logic [2:0] draw_y,
    output logic [1:0] draw_color,
    input  logic       draw_ack,
    output logic       busy,
    output logic       done,
    output logic       legal,
    output logic [4:0] flip_count
);

    state_t     state_q, state_d;
    logic [2:0] x_q, x_d;
    logic [2:0] y_q, y_d;
    logic       side_q, side_d;
    logic       commit_q, commit_d;
    logic [2:0] dir_q, dir_d;
    logic [3:0] k_q, k_d;
    logic [1:0] wait_q, wait_d;
    logic [1:0] cell_q, cell_d;
    logic [4:0] flip_q, flip_d;
    logic       legal_q, legal_d;

    logic [2:0] step_x;
    logic [2:0] step_y;
    logic       step_ok;
    logic [1:0] own_cell;
    logic [1:0] opp_cell;

    board_step u_step (
        .x         (x_q),
        .y         (y_q),
        .dir       (dir_q),
        .k         (k_q),
        .nx        (step_x),
        .ny        (step_y),
        .in_bounds (step_ok)
    );

    assign own_cell   = side_q ? CELL_WHITE : CELL_BLACK;
    assign opp_cell   = side_q ? CELL_BLACK : CELL_WHITE;
    assign legal      = legal_q;
    assign flip_count = flip_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        side_d     = side_q;
        commit_d   = commit_q;
        dir_d      = dir_q;
        k_d        = k_q;
        wait_d     = wait_q;
        cell_d     = cell_q;
        flip_d     = flip_q;
        legal_d    = legal_q;
        mem_addr   = 6'd0;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = CELL_EMPTY;
        draw_req   = 1'b0;
        draw_x     = 3'd0;
        draw_y     = 3'd0;
        draw_color = CELL_EMPTY;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    x_d      = pos_x;
                    y_d      = pos_y;
                    side_d   = side;
                    commit_d = commit;
                    dir_d    = 3'd0;
                    flip_d   = 5'd0;
                    legal_d  = 1'b0;
                    state_d  = ORG_RD;
                end
            end
            ORG_RD: begin
                mem_rd   = 1'b1;
                mem_addr = {y_q, x_q};
                wait_d   = 2'd1;
                state_d  = ORG_WAIT;
            end
            ORG_WAIT: begin
                mem_addr = {y_q, x_q};
                if (wait_q == 2'(RD_LAT)) begin
                    state_d = (mem_rdata != CELL_EMPTY) ? FINISH : DIR_INIT;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            DIR_INIT: begin
                k_d     = 4'd1;
                state_d = STEP_RD;
            end
            STEP_RD: begin
                if (!step_ok) begin
                    state_d = NEXT_DIR;
                end else begin
                    mem_rd   = 1'b1;
                    mem_addr = {step_y, step_x};
                    wait_d   = 2'd1;
                    state_d  = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                mem_addr = {step_y, step_x};
                if (wait_q == 2'(RD_LAT)) begin
                    cell_d  = mem_rdata;
                    state_d = STEP_EVAL;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            STEP_EVAL: begin
                if (cell_q == opp_cell) begin
                    k_d     = k_q + 4'd1;
                    state_d = STEP_RD;
                end else if (cell_q == own_cell && k_q >= 4'd2) begin
                    flip_d = flip_q + 5'(k_q - 4'd1);
                    if (commit_q) begin
                        k_d     = k_q - 4'd1;
                        state_d = BACK_WR;
                    end else begin
                        state_d = NEXT_DIR;
                    end
                end else begin
                    state_d = NEXT_DIR;
                end
            end
            BACK_WR: begin
                mem_we    = 1'b1;
                mem_addr  = {step_y, step_x};
                mem_wdata = own_cell;
                state_d   = BACK_DRAW;
            end
            // The write cycle in between guarantees draw_req drops after each ack.
            BACK_DRAW: begin
                draw_req   = 1'b1;
                draw_x     = step_x;
                draw_y     = step_y;
                draw_color = own_cell;
                if (draw_ack) begin
                    if (k_q == 4'd1) begin
                        state_d = NEXT_DIR;
                    end else begin
                        k_d     = k_q - 4'd1;
                        state_d = BACK_WR;
                    end
                end
            end
            NEXT_DIR: begin
                if (dir_q == 3'd7) begin
                    legal_d = (flip_q != 5'd0);
                    state_d = (commit_q && flip_q != 5'd0) ? PLACE_WR : FINISH;
                end else begin
                    dir_d   = dir_q + 3'd1;
                    state_d = DIR_INIT;
                end
            end
            PLACE_WR: begin
                mem_we    = 1'b1;
                mem_addr  = {y_q, x_q};
                mem_wdata = own_cell;
                state_d   = PLACE_DRAW;
            end
            PLACE_DRAW: begin
                draw_req   = 1'b1;
                draw_x     = x_q;
                draw_y     = y_q;
                draw_color = own_cell;
                if (draw_ack) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q  <= IDLE;
            x_q      <= 3'd0;
            y_q      <= 3'd0;
            side_q   <= 1'b0;
            commit_q <= 1'b0;
            dir_q    <= 3'd0;
            k_q      <= 4'd0;
            wait_q   <= 2'd0;
            cell_q   <= CELL_EMPTY;
            flip_q   <= 5'd0;
            legal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            side_q   <= side_d;
            commit_q <= commit_d;
            dir_q    <= dir_d;
            k_q      <= k_d;
            wait_q   <= wait_d;
            cell_q   <= cell_d;
            flip_q   <= flip_d;
            legal_q  <= legal_d;
        end
    end

endmodule

// File: tb/tb_flip_sequencer.sv
// Scoreboard bench for flip_sequencer: a reference Othello model predicts the
// result plus the ordered writes/redraws, which monitors pop as the DUT emits them.
module tb_flip_sequencer;

    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       restart;
    logic       start;
    logic       commit;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic       side;
    logic [5:0] mem_addr;
    logic       mem_rd;
    logic [1:0] mem_rdata;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic       draw_req;
    logic [2:0] draw_x;
    logic [2:0] draw_y;
    logic [1:0] draw_color;
    logic       draw_ack;
    logic       busy;
    logic       done;
    logic       legal;
    logic [4:0] flip_count;

    logic [1:0] board [64];
    logic [1:0] rdataQ;
    logic [7:0] expWr[$];
    logic [7:0] expDraw[$];
    logic       expLegal;
    int         expFlip;
    int         checks = 0;
    int         failures = 0;
    int         ackDelay = 0;
    int         ackCnt = 0;
    int         doneCount = 0;
    int         rdCount = 0;
    int         lastLatency = 0;
    logic       prevReq = 1'b0;
    logic       prevAck = 1'b0;
    logic [8:0] prevBundle = 9'd0;

    flip_sequencer #(.RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .restart    (restart),
        .start      (start),
        .commit     (commit),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .side       (side),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .draw_req   (draw_req),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_color (draw_color),
        .draw_ack   (draw_ack),
        .busy       (busy),
        .done       (done),
        .legal      (legal),
        .flip_count (flip_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = rdataQ;

    // Board RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd) rdataQ <= board[mem_addr];
        if (mem_we) board[mem_addr] <= mem_wdata;
    end

    // Drawer acks after ackDelay extra cycles of a pending request.
    always @(posedge clk) begin
        if (draw_req && !draw_ack) begin
            if (ackCnt >= ackDelay) draw_ack <= 1'b1;
            else ackCnt <= ackCnt + 1;
        end else begin
            draw_ack <= 1'b0;
            ackCnt   <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (done) doneCount++;
        if (mem_rd) rdCount++;
        if (mem_we) begin
            checkOutput("rd_we_excl", {31'd0, mem_rd}, 32'd0);
            if (expWr.size() > 0) checkOutput("write", {24'd0, mem_addr[2:0], mem_addr[5:3], mem_wdata}, {24'd0, expWr.pop_front()});
            else checkOutput("write_extra", {31'd0, mem_we}, 32'd0);
        end
        if (draw_req && draw_ack) begin
            if (expDraw.size() > 0) checkOutput("draw", {24'd0, draw_x, draw_y, draw_color}, {24'd0, expDraw.pop_front()});
            else checkOutput("draw_extra", {31'd0, draw_req}, 32'd0);
        end
        if (prevReq && !prevAck)
            checkOutput("req_hold", {23'd0, draw_req, draw_x, draw_y, draw_color}, {23'd0, prevBundle});
        if (prevReq && prevAck)
            checkOutput("req_drop", {31'd0, draw_req}, 32'd0);
        prevReq    = draw_req;
        prevAck    = draw_ack;
        prevBundle = {draw_req, draw_x, draw_y, draw_color};
    end

    task automatic clearBoard();
        for (int i = 0; i < 64; i++) board[i] <= 2'b00;
    endtask

    task automatic setCell(input int x, input int y, input logic [1:0] c);
        board[y*8 + x] <= c;
    endtask

    task automatic setOpening();
        clearBoard();
        setCell(3, 3, 2'b10);
        setCell(4, 4, 2'b10);
        setCell(3, 4, 2'b01);
        setCell(4, 3, 2'b01);
    endtask

    task automatic setMulti();
        clearBoard();
        setCell(2, 2, 2'b10);
        setCell(3, 3, 2'b10);
        setCell(4, 4, 2'b01);
        setCell(2, 1, 2'b10);
        setCell(3, 1, 2'b10);
        setCell(4, 1, 2'b01);
    endtask

    // Reference Othello rules, with expected write/redraw order.
    task automatic modelMove(input int px, input int py, input logic sd, input logic cm);
        int dxs[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
        int dys[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        logic [1:0] own;
        logic [1:0] opp;
        int k, n, cx, cy;
        bit walking;
        own = sd ? 2'b10 : 2'b01;
        opp = sd ? 2'b01 : 2'b10;
        expWr.delete();
        expDraw.delete();
        expFlip  = 0;
        expLegal = 1'b0;
        if (board[py*8 + px] != 2'b00) return;
        for (int d = 0; d < 8; d++) begin
            k = 1;
            n = 0;
            walking = 1'b1;
            while (walking) begin
                cx = px + dxs[d]*k;
                cy = py + dys[d]*k;
                if (cx < 0 || cx > 7 || cy < 0 || cy > 7) begin
                    walking = 1'b0;
                end else if (board[cy*8 + cx] == opp) begin
                    k++;
                end else begin
                    if (board[cy*8 + cx] == own && k >= 2) n = k - 1;
                    walking = 1'b0;
                end
            end
            expFlip += n;
            if (cm) begin
                for (int j = n; j >= 1; j--) begin
                    expWr.push_back({3'(px + dxs[d]*j), 3'(py + dys[d]*j), own});
                    expDraw.push_back({3'(px + dxs[d]*j), 3'(py + dys[d]*j), own});
                end
            end
        end
        expLegal = (expFlip != 0);
        if (cm && expLegal) begin
            expWr.push_back({3'(px), 3'(py), own});
            expDraw.push_back({3'(px), 3'(py), own});
        end
    endtask

    task automatic startOp(input int px, input int py, input logic sd, input logic cm);
        @(negedge clk);
        modelMove(px, py, sd, cm);
        doneCount = 0;
        rdCount   = 0;
        pos_x  = 3'(px);
        pos_y  = 3'(py);
        side   = sd;
        commit = cm;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic applyStimulus(input int px, input int py, input logic sd, input logic cm);
        int cycles;
        startOp(px, py, sd, cm);
        cycles = 1;
        while (!done && cycles < 600) begin
            @(negedge clk);
            cycles++;
        end
        lastLatency = cycles;
        checkOutput("done_seen", {31'd0, done}, 32'd1);
        checkOutput("done_busy_low", {31'd0, busy}, 32'd0);
        checkOutput("legal", {31'd0, legal}, {31'd0, expLegal});
        checkOutput("flip_count", {27'd0, flip_count}, 32'(expFlip));
        repeat (4) @(negedge clk);
        checkOutput("done_pulses", 32'(doneCount), 32'd1);
        checkOutput("legal_held", {31'd0, legal}, {31'd0, expLegal});
        checkOutput("writes_left", 32'(expWr.size()), 32'd0);
        checkOutput("draws_left", 32'(expDraw.size()), 32'd0);
    endtask

    initial begin
        int guard;
        restart  = 1'b1;
        start    = 1'b0;
        commit   = 1'b0;
        pos_x    = 3'd0;
        pos_y    = 3'd0;
        side     = 1'b0;
        draw_ack = 1'b0;
        rdataQ   = 2'b00;
        clearBoard();
        repeat (3) @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs", {5'd0, mem_addr, mem_rd, mem_we, mem_wdata, draw_req, draw_x, draw_y,
                    draw_color, busy, done, legal, flip_count}, 32'd0);

        setOpening();
        applyStimulus(2, 3, 1'b0, 1'b1);
        checkOutput("opening_commit_flip", {27'd0, flip_count}, 32'd1);

        setOpening();
        applyStimulus(2, 3, 1'b0, 1'b0);
        checkOutput("opening_check_legal", {31'd0, legal}, 32'd1);

        setOpening();
        applyStimulus(0, 0, 1'b0, 1'b1);

        setOpening();
        applyStimulus(3, 3, 1'b0, 1'b1);
        checkOutput("occupied_reads", 32'(rdCount), 32'd1);
        checkOutput("occupied_latency", {31'd0, lastLatency <= RD_LAT + 3}, 32'd1);

        clearBoard();
        setCell(5, 3, 2'b10);
        setCell(6, 3, 2'b10);
        setCell(7, 3, 2'b10);
        setCell(0, 3, 2'b01);
        applyStimulus(4, 3, 1'b0, 1'b1);
        checkOutput("no_wrap_legal", {31'd0, legal}, 32'd0);

        ackDelay = 3;
        setMulti();
        applyStimulus(1, 1, 1'b0, 1'b1);
        checkOutput("multi_flip", {27'd0, flip_count}, 32'd4);

        for (int r = 0; r < 6; r++) begin
            int px, py;
            for (int i = 0; i < 64; i++) board[i] <= 2'($urandom_range(0, 2));
            px = $urandom_range(0, 7);
            py = $urandom_range(0, 7);
            if (r % 3 != 2) setCell(px, py, 2'b00);
            ackDelay = $urandom_range(0, 2);
            applyStimulus(px, py, 1'($urandom_range(0, 1)), 1'(r % 2 == 0));
        end

        // Restart on the first flip write: nothing further may be written or drawn.
        ackDelay = 3;
        setMulti();
        startOp(1, 1, 1'b0, 1'b1);
        guard = 0;
        while (!mem_we && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("restart_we_seen", {31'd0, mem_we}, 32'd1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        expWr.delete();
        expDraw.delete();
        checkOutput("restart_outputs", {5'd0, mem_addr, mem_rd, mem_we, mem_wdata, draw_req, draw_x, draw_y,
                    draw_color, busy, done, legal, flip_count}, 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("restart_no_done", 32'(doneCount), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
